// File: rtl/addsub_seq_if.sv
// -----------------------------------------------------------------------------
// addsub_seq_if
// Handshake and operand/result bundle for the slice-serial add/subtract unit.
//
//   start  : request, sampled only while the unit is not busy
//   op     : 0 = add, 1 = subtract
//   cin    : carry-in (add) / borrow-in (subtract)
//   Ra, Rb : operands
//   busy   : operation in progress
//   done   : one-cycle pulse, result and flags valid
//   result : sum / difference, held until the next completion
//   cout   : carry out of the MSB (subtract: 1 = no borrow)
//   ovf    : signed two's-complement overflow
//   zero   : result == 0
//   neg    : result MSB
//
// master : the requester (drives start/op/cin/operands)
// slave  : the arithmetic unit
// -----------------------------------------------------------------------------
interface addsub_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic             cin;
    logic [WIDTH-1:0] Ra;
    logic [WIDTH-1:0] Rb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output start, op, cin, Ra, Rb,
        input  busy, done, result, cout, ovf, zero, neg
    );

    modport slave (
        input  start, op, cin, Ra, Rb,
        output busy, done, result, cout, ovf, zero, neg
    );
endinterface

// File: rtl/addsub_seq.sv
// -----------------------------------------------------------------------------
// addsub_seq
// Multi-cycle add/subtract unit. Operands are latched on acceptance and then
// processed SLICE bits per clock from LSB to MSB, so the carry chain per cycle
// is only SLICE bits long. Result and flags (cout, ovf, zero, neg) update
// together on completion and hold until the next operation completes.
//
// Ports:
//   clk : rising-edge clock
//   clr : synchronous active-low reset (aborts any operation in progress)
//   bus : addsub_seq_if.slave handshake / operand / result bundle
//
// Latency: start accepted at edge 0, slices processed on edges 1..N,
// done high during the cycle after edge N (N = WIDTH / SLICE).
// -----------------------------------------------------------------------------
module addsub_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic         clk,
    input  logic         clr,
    addsub_seq_if.slave  bus
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("addsub_seq: WIDTH (%0d) must be an integer multiple of SLICE (%0d)",
                   WIDTH, SLICE);
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Control strobes decoded from the FSM
    logic accept;   // latch operands and begin a new operation
    logic step;     // process one slice
    logic finish;   // this step handles the final slice

    // Datapath registers
    logic [WIDTH-1:0] a_q;      // A, shifted right one slice per step
    logic [WIDTH-1:0] b_q;      // B' (already inverted for subtract), shifted likewise
    logic [WIDTH-1:0] acc;      // partial result, slices enter at the top
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;    // sign bits kept for the overflow flag
    logic             b_msb;

    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] acc_nxt;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves a signal unassigned, which would infer a latch.
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // start is deliberately not looked at here: ignored, not queued
                step = 1'b1;
                if (cnt == LAST) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Accepting here gives back-to-back operation with no idle gap
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_DONE);

    // -------------------------------------------------------------------------
    // Slice adder
    // -------------------------------------------------------------------------
    always_comb begin
        slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]}
                  + {{SLICE{1'b0}}, carry};
        // After N steps the first slice has shifted down to bit 0
        acc_nxt   = (acc >> SLICE)
                  | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
    end

    // NOTE: the working registers are not reset; every one is loaded on
    // acceptance or fully overwritten before it is used, and an abort leaves
    // the FSM in IDLE where their contents are never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= bus.Ra;
            b_q   <= bus.op ? ~bus.Rb : bus.Rb;
            carry <= bus.op ? ~bus.cin : bus.cin;
            a_msb <= bus.Ra[WIDTH-1];
            b_msb <= bus.op ? ~bus.Rb[WIDTH-1] : bus.Rb[WIDTH-1];
            cnt   <= '0;
        end else if (step) begin
            a_q   <= a_q >> SLICE;
            b_q   <= b_q >> SLICE;
            acc   <= acc_nxt;
            carry <= slice_sum[SLICE];
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Architectural result and flags: change only on completion
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr) begin
            bus.result <= '0;
            bus.cout   <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.zero   <= 1'b0;
            bus.neg    <= 1'b0;
        end else if (finish) begin
            bus.result <= acc_nxt;
            bus.cout   <= slice_sum[SLICE];
            bus.ovf    <= (a_msb == b_msb) && (acc_nxt[WIDTH-1] != a_msb);
            bus.zero   <= (acc_nxt == '0);
            bus.neg    <= acc_nxt[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_addsub_seq
// Directed bench for addsub_seq: a vector table on a WIDTH=32/SLICE=8 unit,
// hand-written handshake/reset sequences, and the WIDTH=16/SLICE=4 and
// WIDTH=8/SLICE=8 configurations. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_addsub_seq;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    addsub_seq_if #(.WIDTH(32)) bus32 ();
    addsub_seq_if #(.WIDTH(16)) bus16 ();
    addsub_seq_if #(.WIDTH(8))  bus8  ();

    addsub_seq #(.WIDTH(32), .SLICE(8)) dut32 (.clk(clk), .clr(clr), .bus(bus32));
    addsub_seq #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .clr(clr), .bus(bus16));
    addsub_seq #(.WIDTH(8),  .SLICE(8)) dut8  (.clk(clk), .clr(clr), .bus(bus8));

    int pass_cnt  = 0;
    int check_cnt = 0;

    // flags packing: {cout, ovf, zero, neg}
    typedef struct {
        logic        op;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // sel: 0 = 32/8, 1 = 16/4, 2 = 8/8
    task automatic drive(input int sel, input logic s, input logic o, input logic c,
                         input logic [31:0] a, input logic [31:0] b);
        case (sel)
            0: begin
                bus32.start = s; bus32.op = o; bus32.cin = c;
                bus32.Ra = a; bus32.Rb = b;
            end
            1: begin
                bus16.start = s; bus16.op = o; bus16.cin = c;
                bus16.Ra = a[15:0]; bus16.Rb = b[15:0];
            end
            default: begin
                bus8.start = s; bus8.op = o; bus8.cin = c;
                bus8.Ra = a[7:0]; bus8.Rb = b[7:0];
            end
        endcase
    endtask

    function automatic logic dut_done(input int sel);
        case (sel)
            0:       return bus32.done;
            1:       return bus16.done;
            default: return bus8.done;
        endcase
    endfunction

    function automatic logic dut_busy(input int sel);
        case (sel)
            0:       return bus32.busy;
            1:       return bus16.busy;
            default: return bus8.busy;
        endcase
    endfunction

    function automatic logic [31:0] dut_result(input int sel);
        case (sel)
            0:       return bus32.result;
            1:       return {16'h0, bus16.result};
            default: return {24'h0, bus8.result};
        endcase
    endfunction

    function automatic logic [3:0] dut_flags(input int sel);
        case (sel)
            0:       return {bus32.cout, bus32.ovf, bus32.zero, bus32.neg};
            1:       return {bus16.cout, bus16.ovf, bus16.zero, bus16.neg};
            default: return {bus8.cout, bus8.ovf, bus8.zero, bus8.neg};
        endcase
    endfunction

    // Present a one-cycle start; returns at the falling edge after the
    // accepting rising edge (edge count 1 since start).
    task automatic start_op(input int sel, input logic o, input logic c,
                            input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive(sel, 1'b1, o, c, a, b);
        @(negedge clk);
        drive(sel, 1'b0, o, c, a, b);
    endtask

    // Wait (bounded) for done; edges = rising edges since the start edge,
    // counting the start edge as 1.
    task automatic wait_done(input int sel, input int first_edge,
                             output int edges, output int busy_cycles);
        edges       = first_edge;
        busy_cycles = 0;
        while (!dut_done(sel) && edges < 40) begin
            if (dut_busy(sel)) busy_cycles++;
            @(negedge clk);
            edges++;
        end
    endtask

    initial begin
        int edges;
        int bcyc;
        int pulses;

        //          op    cin   a             b             result        {co,ov,z,n}
        vecs[0] = '{1'b0, 1'b0, 32'h00000024, 32'h00000001, 32'h00000025, 4'b0000};
        vecs[1] = '{1'b1, 1'b0, 32'h00000024, 32'h00000001, 32'h00000023, 4'b1000};
        vecs[2] = '{1'b1, 1'b0, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b0001};
        vecs[3] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFFFEFF, 4'b1001};
        vecs[4] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010};
        vecs[6] = '{1'b0, 1'b1, 32'h000000FF, 32'h00000000, 32'h00000100, 4'b0000};
        vecs[7] = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1100};
        vecs[8] = '{1'b0, 1'b0, 32'h12345678, 32'h87654321, 32'h99999999, 4'b0001};
        vecs[9] = '{1'b1, 1'b0, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1010};

        clr = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_busy",   bus32.busy, 0);
        check("reset_done",   bus32.done, 0);
        check("reset_result", dut_result(0), 0);
        check("reset_flags",  dut_flags(0), 0);
        clr = 1'b1;

        // Vector table on the 32/8 unit
        for (int i = 0; i < 10; i++) begin
            start_op(0, vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b);
            wait_done(0, 1, edges, bcyc);
            check($sformatf("v%0d_latency", i), edges, 5);
            check($sformatf("v%0d_busy_cycles", i), bcyc, 4);
            check($sformatf("v%0d_result", i), dut_result(0), vecs[i].res);
            check($sformatf("v%0d_flags", i), dut_flags(0), vecs[i].flags);
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), bus32.done, 0);
        end

        // Start while busy is ignored and not queued; inputs may change freely
        start_op(0, 1'b0, 1'b0, 32'd1, 32'd2);
        drive(0, 1'b1, 1'b1, 1'b0, 32'hFF, 32'h10);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b1, 32'hAAAA, 32'h5555);
        wait_done(0, 2, edges, bcyc);
        check("ignore_latency", edges, 5);
        check("ignore_result", dut_result(0), 32'd3);
        @(negedge clk);
        check("ignore_not_queued_busy", bus32.busy, 0);
        check("ignore_not_queued_done", bus32.done, 0);

        // Back-to-back: start in the DONE cycle
        start_op(0, 1'b0, 1'b0, 32'd10, 32'd20);
        wait_done(0, 1, edges, bcyc);
        check("b2b_first_result", dut_result(0), 32'd30);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("b2b_accept_busy", bus32.busy, 1);
        check("b2b_accept_done", bus32.done, 0);
        check("b2b_result_held", dut_result(0), 32'd30);
        wait_done(0, 1, edges, bcyc);
        check("b2b_latency", edges, 5);
        check("b2b_second_result", dut_result(0), 32'h300);

        // Reset during RUN aborts the operation
        @(negedge clk);
        start_op(0, 1'b0, 1'b0, 32'd7, 32'd8);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        check("abort_busy",   bus32.busy, 0);
        check("abort_done",   bus32.done, 0);
        check("abort_result", dut_result(0), 0);
        check("abort_flags",  dut_flags(0), 0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus32.done) pulses++;
        end
        check("abort_no_done_pulse", pulses, 0);
        check("abort_stays_idle", bus32.busy, 0);

        // WIDTH=16, SLICE=4: N=4
        start_op(1, 1'b0, 1'b0, 32'h0000FFFF, 32'h00000001);
        wait_done(1, 1, edges, bcyc);
        check("w16_latency", edges, 5);
        check("w16_result", dut_result(1), 32'h0);
        check("w16_flags", dut_flags(1), 4'b1010);

        // WIDTH=8, SLICE=8: N=1
        start_op(2, 1'b1, 1'b0, 32'h00000080, 32'h00000001);
        wait_done(2, 1, edges, bcyc);
        check("w8_latency", edges, 2);
        check("w8_result", dut_result(2), 32'h7F);
        check("w8_flags", dut_flags(2), 4'b1100);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle add/subtract unit for the datapath ALU.
- Processes operands SLICE bits per clock from LSB to MSB, so wide adds close timing at high clock rates.
- Controlled by a start/busy/done handshake.
- Adds selectable add/subtract with carry/borrow-in and a full flag set (carry, signed overflow, zero, negative).

Parameters:
- WIDTH, 32, operand/result width in bits.
- SLICE, 8, bits processed per cycle. WIDTH must be an integer multiple of SLICE; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  synchronous active-low reset
- start  input  1  request; sampled only when not busy
- op  input  1  0 = add, 1 = subtract
- cin  input  1  add: carry-in; subtract: borrow-in
- Ra  input  WIDTH  operand A
- Rb  input  WIDTH  operand B
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result/flags valid
- result  output  WIDTH  sum/difference
- cout  output  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  result == 0
- neg  output  1  result[WIDTH-1]

Behaviour:
- Reset: clk and clr are the only clock/reset. Reset is synchronous: clr low at a rising edge clears FSM to IDLE and clears busy, done, result, cout, ovf, zero and neg to 0. It overrides everything, including mid-operation; the partial result is discarded.
- Arithmetic:
  - add: Ra + Rb + cin.
  - sub: Ra + ~Rb + ~cin, i.e. Ra - Rb - cin.
  - Result is taken mod 2^WIDTH.
  - cout is the final carry out of the (possibly inverted-B) sum.
  - ovf = (A[msb] == B'[msb]) && (result[msb] != A[msb]), where B' is the post-inversion operand.
- FSM states: IDLE, RUN, DONE. N = WIDTH/SLICE.
- IDLE:
  - start=1 at an edge latches Ra, Rb, op and cin into internal registers.
  - The slice counter loads 0 and the carry register loads the initial carry (cin for add, ~cin for sub).
  - Go to RUN; busy=1 from the next cycle.
- RUN:
  - Each edge adds slice[cnt] of the latched operands plus the carry register.
  - Writes the slice into the result shift/accumulate register, updates carry, increments cnt.
  - On the edge processing slice N-1: update result, cout, ovf, zero and neg together; busy goes to 0, done to 1; go to DONE.
  - Latency: done is high in the cycle after the Nth RUN edge, i.e. N+1 edges after the start edge.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - A start asserted during DONE is accepted, giving back-to-back operation with no idle gap.
- Inputs Ra, Rb, op and cin may change freely while busy; only the values latched at acceptance are used.
- start while busy=1 is ignored and not queued.
- result and flags are updated only on completion. They hold their value through IDLE and through the next operation's RUN until that operation's done.
- zero and neg reflect the full WIDTH result, not the last slice.
- SLICE == WIDTH is legal: N=1, done 2 edges after start.

Test Plan:
1. WIDTH=32, SLICE=8: add Ra=0x00000024, Rb=0x00000001, cin=0.
   -> Exactly 4 cycles of busy, then a done pulse; result=0x00000025, cout=0, ovf=0, zero=0, neg=0.
2. sub Ra=0x00000024, Rb=0x00000001, cin=0 -> result=0x00000023, cout=1 (no borrow).
   sub Ra=0x00000001, Rb=0x00000002, cin=0 -> result=0xFFFFFFFF, cout=0, neg=1.
3. sub Ra=0xFFFFFFFF, Rb=0x000000FF, cin=1 (borrow-in) -> result=0xFFFFFEFF, cout=1, neg=1, ovf=0.
4. add Ra=0x7FFFFFFF, Rb=0x00000001, cin=0 -> result=0x80000000, ovf=1, neg=1, cout=0.
   Then add 0xFFFFFFFF + 0x00000001 -> result=0, zero=1, cout=1, ovf=0.
5. Handshake and reset:
   - Pulse start again while busy with different operands -> ignored; first result unchanged.
   - Start in the DONE cycle -> accepted; second done 5 edges later.
   - Drive clr low during RUN -> next edge busy=0, done=0, result=0, and no done pulse appears.
6. WIDTH=16, SLICE=4: add 0xFFFF + 0x0001 -> result=0x0000, cout=1, zero=1, done 5 edges after start.
   WIDTH=8, SLICE=8: sub 0x80 - 0x01 -> result=0x7F, ovf=1, done 2 edges after start.
